// File: rtl/dcache_mon_pkg.sv
// dcache_mon_pkg: shared error codes, monitor states, default parameters and the onehot0 helper
package dcache_mon_pkg;
  localparam int unsigned NR_PORTS_DEF = 5;
  localparam int unsigned NR_BYPASS_DEF = 3;
  localparam int unsigned STARVE_LIMIT_DEF = 64;
  localparam int unsigned CNT_WIDTH_DEF = 16;
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_MULTI_GNT = 3'd1,
    ERR_GNT_NO_REQ = 3'd2,
    ERR_STARVE = 3'd3,
    ERR_BYPASS_MULTI = 3'd4
  } err_code_e;
  typedef enum logic [1:0] {DISABLED, MONITOR, ERROR} mon_state_e;
  function automatic logic onehot0(input logic [31:0] v);
    return (v & (v - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/dcache_starve_cnt.sv
// dcache_starve_cnt: per-port wait counter; starve_o when wait hits STARVE_LIMIT, hit_o when it will reach it this cycle
module dcache_starve_cnt #(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  input  logic req_i,
  input  logic gnt_i,
  output logic starve_o,
  output logic hit_o
);
  localparam int unsigned W = $clog2(STARVE_LIMIT + 1);
  localparam logic [W-1:0] LIM = W'(STARVE_LIMIT);
  logic [W-1:0] wait_q, wait_d;
  always_comb begin
    wait_d = clear_i ? '0 : !en_i ? wait_q : (gnt_i || !req_i) ? '0 : (wait_q == LIM) ? wait_q : wait_q + 1'b1;
    hit_o = wait_d == LIM;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
      starve_o <= 1'b0;
    end else begin
      wait_q <= wait_d;
      starve_o <= wait_d == LIM;
    end
  end
endmodule

// File: rtl/dcache_gnt_mon.sv
// dcache_gnt_mon: arbiter grant monitor; counts grants, flags starvation, latches first violation (code/port/time)
module dcache_gnt_mon
  import dcache_mon_pkg::*;
#(
  parameter int unsigned NR_PORTS = NR_PORTS_DEF,
  parameter int unsigned NR_BYPASS = NR_BYPASS_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                en_i,
  input  logic                                clear_i,
  input  logic [NR_PORTS-1:0]                 req_i,
  input  logic [NR_PORTS-1:0]                 gnt_i,
  input  logic [NR_PORTS-1:0]                 rd_gnt_i,
  input  logic [NR_BYPASS-1:0]                bypass_gnt_i,
  output logic [NR_PORTS-1:0][CNT_WIDTH-1:0]  gnt_cnt_o,
  output logic [NR_PORTS-1:0]                 starve_o,
  output logic                                err_o,
  output logic [2:0]                          err_code_o,
  output logic [$clog2(NR_PORTS)-1:0]         err_port_o,
  output logic [CNT_WIDTH-1:0]                err_time_o
);
  localparam int unsigned PW = $clog2(NR_PORTS);
  mon_state_e state_q, state_d;
  err_code_e code_d;
  logic [PW-1:0] port_d;
  logic [NR_PORTS-1:0] hit;
  logic [CNT_WIDTH-1:0] ts_q;
  logic viol;
  function automatic logic [PW-1:0] lowest(input logic [NR_PORTS-1:0] v);
    lowest = '0;
    for (int i = NR_PORTS - 1; i >= 0; i--) if (v[i]) lowest = PW'(i);
  endfunction
  for (genvar g = 0; g < NR_PORTS; g++) begin : g_starve
    dcache_starve_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .clear_i(clear_i),
      .req_i(req_i[g]), .gnt_i(gnt_i[g]), .starve_o(starve_o[g]), .hit_o(hit[g])
    );
  end
  always_comb begin
    code_d = ERR_NONE;
    port_d = '0;
    if (!onehot0(32'(gnt_i))) begin
      code_d = ERR_MULTI_GNT;
      port_d = lowest(gnt_i);
    end else if (|(gnt_i & ~req_i)) begin
      code_d = ERR_GNT_NO_REQ;
      port_d = lowest(gnt_i & ~req_i);
    end else if (|hit) begin
      code_d = ERR_STARVE;
      port_d = lowest(hit);
    end else if (!onehot0(32'(bypass_gnt_i))) begin
      code_d = ERR_BYPASS_MULTI;
    end
    // only the first violation is kept; a sticky error left over from before a disable still blocks new ones
    viol = en_i && !clear_i && !err_o && state_q != ERROR && code_d != ERR_NONE;
    state_d = state_q;
    if (!en_i) state_d = DISABLED;
    else if (clear_i) state_d = MONITOR;
    else if (viol) state_d = ERROR;
    else if (state_q == DISABLED) state_d = err_o ? ERROR : MONITOR;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DISABLED;
      ts_q <= '0;
      gnt_cnt_o <= '0;
      err_o <= 1'b0;
      err_code_o <= '0;
      err_port_o <= '0;
      err_time_o <= '0;
    end else begin
      state_q <= state_d;
      if (clear_i) begin
        ts_q <= '0;
        gnt_cnt_o <= '0;
        err_o <= 1'b0;
        err_code_o <= '0;
        err_port_o <= '0;
        err_time_o <= '0;
      end else begin
        if (en_i) ts_q <= ts_q + 1'b1;
        for (int p = 0; p < NR_PORTS; p++)
          if (en_i && (gnt_i[p] || rd_gnt_i[p]) && !(&gnt_cnt_o[p])) gnt_cnt_o[p] <= gnt_cnt_o[p] + 1'b1;
        if (viol) begin
          err_o <= 1'b1;
          err_code_o <= code_d;
          err_port_o <= port_d;
          err_time_o <= ts_q;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_gnt_mon.sv
// tb_dcache_gnt_mon: directed scoreboard bench for dcache_gnt_mon
module tb_dcache_gnt_mon;
  import dcache_mon_pkg::*;
  typedef enum {K_CNT, K_STARVE, K_ERR, K_CODE, K_PORT, K_TIME, K_SAT, K_STATE} kind_e;
  typedef struct {kind_e k; int p; logic [31:0] v; string tag;} exp_t;
  logic clk = 1'b0;
  logic rst, en, clr;
  logic [4:0] req, gnt, rd;
  logic [2:0] byp;
  logic [4:0][15:0] cnt;
  logic [4:0] starve;
  logic err;
  logic [2:0] code, port;
  logic [15:0] tm;
  logic [4:0][3:0] s_cnt;
  logic [4:0] s_starve;
  logic s_err;
  logic [2:0] s_code, s_port;
  logic [3:0] s_tm;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dcache_gnt_mon dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .req_i(req), .gnt_i(gnt),
    .rd_gnt_i(rd), .bypass_gnt_i(byp), .gnt_cnt_o(cnt), .starve_o(starve), .err_o(err),
    .err_code_o(code), .err_port_o(port), .err_time_o(tm)
  );
  dcache_gnt_mon #(.CNT_WIDTH(4)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .req_i(req), .gnt_i(gnt),
    .rd_gnt_i(rd), .bypass_gnt_i(byp), .gnt_cnt_o(s_cnt), .starve_o(s_starve), .err_o(s_err),
    .err_code_o(s_code), .err_port_o(s_port), .err_time_o(s_tm)
  );
  task automatic ex(input kind_e k, input int p, input logic [31:0] v, input string tag);
    exp_t e;
    e.k = k; e.p = p; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask
  function automatic logic [31:0] obs(input kind_e k, input int p);
    case (k)
      K_CNT:    return 32'(cnt[p]);
      K_STARVE: return 32'(starve[p]);
      K_ERR:    return 32'(err);
      K_CODE:   return 32'(code);
      K_PORT:   return 32'(port);
      K_TIME:   return 32'(tm);
      K_SAT:    return 32'(s_cnt[p]);
      default:  return 32'(dut.state_q);
    endcase
  endfunction
  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.k, e.p);
      checks++;
      assert (o === e.v) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.v);
      end
    end
  endtask
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1 drain();
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = '0; gnt = '0; rd = '0; byp = '0;
    ex(K_ERR, 0, 0, "rst_err"); ex(K_CODE, 0, 0, "rst_code"); ex(K_TIME, 0, 0, "rst_time");
    ex(K_CNT, 0, 0, "rst_cnt0"); ex(K_STARVE, 0, 0, "rst_starve0"); ex(K_STATE, 0, 32'(DISABLED), "rst_state");
    run(1);
    rst = 1'b0; en = 1'b1; req = 5'b00001; gnt = 5'b00001; rd = 5'b00010;
    ex(K_CNT, 0, 10, "cnt0_10"); ex(K_CNT, 1, 10, "cnt1_rd_10"); ex(K_ERR, 0, 0, "no_err"); ex(K_STARVE, 0, 0, "no_starve");
    ex(K_STATE, 0, 32'(MONITOR), "state_mon");
    run(10);
    rd = '0;
    ex(K_CNT, 0, 20, "cnt0_20");
    run(10);
    req = 5'b00110; gnt = 5'b00110;
    ex(K_ERR, 0, 1, "multi_err"); ex(K_CODE, 0, 1, "multi_code"); ex(K_PORT, 0, 1, "multi_port");
    ex(K_TIME, 0, 20, "multi_time"); ex(K_CNT, 1, 11, "multi_cnt1"); ex(K_STATE, 0, 32'(ERROR), "state_err");
    run(1);
    req = '0; gnt = '0; byp = 3'b011;
    ex(K_CODE, 0, 1, "err_hold_code"); ex(K_TIME, 0, 20, "err_hold_time"); ex(K_PORT, 0, 1, "err_hold_port");
    run(2);
    byp = '0; clr = 1'b1;
    ex(K_ERR, 0, 0, "clr_err"); ex(K_CNT, 0, 0, "clr_cnt0"); ex(K_STATE, 0, 32'(MONITOR), "clr_state");
    run(1);
    clr = 1'b0; req = 5'b01000;
    ex(K_STARVE, 3, 0, "starve_63"); ex(K_ERR, 0, 0, "starve_63_err");
    run(63);
    ex(K_STARVE, 3, 1, "starve_64"); ex(K_ERR, 0, 1, "starve_err"); ex(K_CODE, 0, 3, "starve_code");
    ex(K_PORT, 0, 3, "starve_port"); ex(K_TIME, 0, 63, "starve_time");
    run(1);
    gnt = 5'b01000;
    ex(K_STARVE, 3, 0, "starve_gnt"); ex(K_CODE, 0, 3, "starve_code_hold"); ex(K_CNT, 3, 1, "cnt3_1");
    run(1);
    req = '0; gnt = 5'b00100; clr = 1'b1;
    ex(K_ERR, 0, 0, "clr_viol_err"); ex(K_CODE, 0, 0, "clr_viol_code"); ex(K_CNT, 3, 0, "clr_viol_cnt3");
    ex(K_CNT, 2, 0, "clr_viol_cnt2"); ex(K_STATE, 0, 32'(MONITOR), "clr_viol_state");
    run(1);
    clr = 1'b0;
    ex(K_ERR, 0, 1, "noreq_err"); ex(K_CODE, 0, 2, "noreq_code"); ex(K_PORT, 0, 2, "noreq_port"); ex(K_TIME, 0, 0, "noreq_time");
    run(1);
    gnt = '0; clr = 1'b1;
    run(1);
    clr = 1'b0; byp = 3'b101;
    ex(K_ERR, 0, 1, "byp_err"); ex(K_CODE, 0, 4, "byp_code"); ex(K_PORT, 0, 0, "byp_port");
    run(1);
    byp = '0; clr = 1'b1;
    run(1);
    clr = 1'b0; en = 1'b0; req = 5'b00110; gnt = 5'b00110;
    ex(K_ERR, 0, 0, "dis_err"); ex(K_STATE, 0, 32'(DISABLED), "dis_state"); ex(K_CNT, 1, 0, "dis_cnt1");
    run(1);
    en = 1'b1; req = '0; gnt = '0;
    ex(K_STATE, 0, 32'(MONITOR), "reen_state");
    run(1);
    req = 5'b10000; gnt = 5'b10000;
    ex(K_SAT, 4, 15, "sat_cnt4"); ex(K_CNT, 4, 20, "cnt4_20");
    run(20);
    ex(K_SAT, 4, 15, "sat_hold"); ex(K_CNT, 4, 21, "cnt4_21");
    run(1);
    req = 5'b00011; gnt = 5'b00011;
    ex(K_ERR, 0, 1, "pre_rst_err"); ex(K_CODE, 0, 1, "pre_rst_code");
    run(1);
    req = 5'b10000; gnt = 5'b10000;
    #3 rst = 1'b1;
    ex(K_ERR, 0, 0, "arst_err"); ex(K_CODE, 0, 0, "arst_code"); ex(K_TIME, 0, 0, "arst_time");
    ex(K_CNT, 4, 0, "arst_cnt4"); ex(K_STATE, 0, 32'(DISABLED), "arst_state");
    #1 drain();
    #1 rst = 1'b0;
    req = 5'b01100; gnt = 5'b01100;
    ex(K_ERR, 0, 1, "post_rst_err"); ex(K_CODE, 0, 1, "post_rst_code"); ex(K_PORT, 0, 2, "post_rst_port");
    ex(K_TIME, 0, 0, "post_rst_time");
    run(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
